mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage directly downstream of execute.
- Accepts one executed instruction per handshake:
  - alu result, used as load/store address or as a pass-through value
  - rs2 store data
  - mem_op, rd index and pc
- Drives a single-outstanding data-memory request/response bus, aligns and extends load data, and presents the writeback result to the writeback stage over a valid/ready handshake.
- Non-memory instructions pass through with one cycle of registered latency.

Parameters:
- XLEN, 64, datapath width; equals `XLEN.
- REG_AW, 5, register index width; equals `REG_ADDRWIDTH.
- MOP_W, `MEMOP_LEN, mem_op encoding width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept.
- in_pc  in  XLEN  instruction pc.
- in_rd_idx  in  REG_AW  destination register.
- in_alu_out  in  XLEN  address (mem ops) or result (others).
- in_rs2_data  in  XLEN  store data.
- in_mem_op  in  MOP_W  `MEMOP_NONE/LB/LBU/LH/LHU/LW/LWU/LD/SB/SH/SW/SD.
- dmem_req_valid  out  1  bus request valid.
- dmem_req_ready  in  1  bus accepts request.
- dmem_addr  out  XLEN  8-byte-aligned address ({addr[XLEN-1:3],3'b0}).
- dmem_wen  out  1  1 = store.
- dmem_wdata  out  XLEN  store data shifted to byte lane.
- dmem_wstrb  out  8  byte enables.
- dmem_rsp_valid  in  1  response valid; one pulse per accepted request.
- dmem_rdata  in  XLEN  aligned 64-bit read data.
- out_valid  out  1  writeback result valid.
- out_ready  in  1  writeback accepts.
- out_pc  out  XLEN  registered pc.
- out_rd_idx  out  REG_AW  registered rd.
- out_rd_wen  out  1  result must be written to rd.
- out_data  out  XLEN  writeback value.
- out_misalign  out  1  address not naturally aligned for its size.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; all out_* and dmem_* outputs 0.
  - Any in-flight request is abandoned; a dmem_rsp_valid arriving after reset in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Acceptance occurs when in_valid & in_ready; all inputs are latched on acceptance.
- On acceptance, the next state is chosen as follows:
  - mem_op==NONE -> DONE; out_data=in_alu_out; out_rd_wen=(rd_idx!=0).
  - Load/store, naturally aligned (H: addr[0]=0; W: addr[1:0]=0; D: addr[2:0]=0) -> REQ.
  - Misaligned -> DONE; out_misalign=1; out_rd_wen=0; out_data=address; no bus request is issued.
- REQ:
  - dmem_req_valid=1; addr, wen, wdata and wstrb are held stable until dmem_req_ready.
  - When dmem_req_ready=1, the handshake completes that cycle: store -> DONE (out_rd_wen=0, out_data=0); load -> WAIT.
- WAIT:
  - dmem_req_valid=0.
  - On dmem_rsp_valid: shift = rdata >> (addr[2:0]*8), then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) from 8/16/32 bits; LD takes rdata directly.
  - The result is registered to out_data; out_rd_wen=(rd_idx!=0); -> DONE.
- DONE:
  - out_valid=1; all out_* fields are held stable until out_ready.
  - out_ready & in_valid: the new instruction is accepted in the same cycle (back-to-back, no bubble).
  - out_ready & !in_valid -> IDLE; out_valid drops next cycle.
- Store lanes: off=addr[2:0].
  - SB: wstrb=8'h01<<off, wdata=rs2[7:0] replicated ×8.
  - SH: wstrb=8'h03<<off, rs2[15:0] replicated ×4.
  - SW: wstrb=8'h0F<<off, rs2[31:0] replicated ×2.
  - SD: wstrb=8'hFF.
- Loads drive dmem_wen=0 and dmem_wstrb=0.
- Minimum latencies (acceptance edge to out_valid): non-mem 1 cycle; store with immediate ready 2 cycles; load with immediate ready and 1-cycle response 3 cycles.
- dmem_rsp_valid outside WAIT is ignored.
- Only one bus transaction is outstanding at a time.

Test Plan:
- Pass-through: NONE, alu_out=0x1234, rd=5, out_ready=1 -> out_valid one cycle after acceptance, out_data=0x1234, out_rd_wen=1; a second NONE is accepted in the DONE cycle with no bubble.
- LB sign-extend: addr=0x80000003, rdata=0x00000000_8F000000 -> dmem_addr=0x80000000, out_data=0xFFFFFFFF_FFFFFF8F; LBU on the same data -> 0x8F.
- SH lanes: addr=0x80000006, rs2=0xABCD -> dmem_wen=1, wstrb=0xC0, wdata=0xABCDABCD_ABCDABCD; out_rd_wen=0.
- Backpressure: LW with dmem_req_ready=0 for 3 cycles -> req fields stable; then with out_ready=0 for 2 cycles -> out fields stable and in_ready=0.
- Misalign: LW at 0x80000002 -> no dmem_req_valid, out_misalign=1, out_data=0x80000002.
- Reset in WAIT: assert rst_n=0 for one cycle, then deliver dmem_rsp_valid -> all outputs 0, state IDLE, response ignored, in_ready=1.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: one outstanding data-memory transaction, load align/extend,
// and a valid/ready handoff of the writeback result.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 5
`endif
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`define MEMOP_NONE 4'd0
`define MEMOP_LB   4'd1
`define MEMOP_LBU  4'd2
`define MEMOP_LH   4'd3
`define MEMOP_LHU  4'd4
`define MEMOP_LW   4'd5
`define MEMOP_LWU  4'd6
`define MEMOP_LD   4'd7
`define MEMOP_SB   4'd8
`define MEMOP_SH   4'd9
`define MEMOP_SW   4'd10
`define MEMOP_SD   4'd11
`endif

module mem_access #(
    parameter int XLEN   = `XLEN,
    parameter int REG_AW = `REG_ADDRWIDTH,
    parameter int MOP_W  = `MEMOP_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rd_idx,
    input  logic [XLEN-1:0]   in_alu_out,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [MOP_W-1:0]  in_mem_op,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [XLEN-1:0]   dmem_addr,
    output logic              dmem_wen,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [7:0]        dmem_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd_idx,
    output logic              out_rd_wen,
    output logic [XLEN-1:0]   out_data,
    output logic              out_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nxt, route;

    logic             accept, is_ld, is_st, is_mem, mis, st_q;
    logic [1:0]       lg_sz;
    logic [2:0]       amask, off_q;
    logic [7:0]       bmask, st_strb;
    logic [XLEN-1:0]  st_wdata, ld_shift, ld_val;
    logic [MOP_W-1:0] op_q;

    // Decode of the incoming op: access size (log2 bytes) and direction.
    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        lg_sz = 2'd0;
        case (in_mem_op)
            `MEMOP_LB, `MEMOP_LBU: is_ld = 1'b1;
            `MEMOP_LH, `MEMOP_LHU: begin is_ld = 1'b1; lg_sz = 2'd1; end
            `MEMOP_LW, `MEMOP_LWU: begin is_ld = 1'b1; lg_sz = 2'd2; end
            `MEMOP_LD:             begin is_ld = 1'b1; lg_sz = 2'd3; end
            `MEMOP_SB:             is_st = 1'b1;
            `MEMOP_SH:             begin is_st = 1'b1; lg_sz = 2'd1; end
            `MEMOP_SW:             begin is_st = 1'b1; lg_sz = 2'd2; end
            `MEMOP_SD:             begin is_st = 1'b1; lg_sz = 2'd3; end
            default: ;
        endcase
        amask = 3'((4'b1 << lg_sz) - 4'd1);
    end

    assign is_mem = is_ld | is_st;
    assign mis    = is_mem & (|(in_alu_out[2:0] & amask));
    assign accept = in_valid & in_ready;
    assign route  = (is_mem & ~mis) ? REQ : DONE;

    always_comb begin
        case (lg_sz)
            2'd0:    begin bmask = 8'h01; st_wdata = {(XLEN/8){in_rs2_data[7:0]}};  end
            2'd1:    begin bmask = 8'h03; st_wdata = {(XLEN/16){in_rs2_data[15:0]}}; end
            2'd2:    begin bmask = 8'h0F; st_wdata = {(XLEN/32){in_rs2_data[31:0]}}; end
            default: begin bmask = 8'hFF; st_wdata = in_rs2_data;                   end
        endcase
    end
    assign st_strb = bmask << in_alu_out[2:0];

    // Bring the addressed bytes down to bit 0, then extend by op.
    assign ld_shift = dmem_rdata >> {off_q, 3'b000};
    always_comb begin
        case (op_q)
            `MEMOP_LB:  ld_val = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            `MEMOP_LBU: ld_val = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            `MEMOP_LH:  ld_val = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            `MEMOP_LHU: ld_val = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            `MEMOP_LW:  ld_val = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
            `MEMOP_LWU: ld_val = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
            default:    ld_val = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = route;
            REQ:     if (dmem_req_ready) state_nxt = st_q ? DONE : WAIT;
            WAIT:    if (dmem_rsp_valid) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? route : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready       = (state == IDLE) | ((state == DONE) & out_ready);
        dmem_req_valid = (state == REQ);
        out_valid      = (state == DONE);
    end

    // Everything is captured at acceptance; only a load result updates later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q         <= '0;
            off_q        <= '0;
            st_q         <= 1'b0;
            dmem_addr    <= '0;
            dmem_wen     <= 1'b0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= '0;
            out_pc       <= '0;
            out_rd_idx   <= '0;
            out_rd_wen   <= 1'b0;
            out_data     <= '0;
            out_misalign <= 1'b0;
        end else if (accept) begin
            op_q         <= in_mem_op;
            off_q        <= in_alu_out[2:0];
            st_q         <= is_st;
            dmem_addr    <= {in_alu_out[XLEN-1:3], 3'b000};
            dmem_wen     <= is_st & ~mis;
            dmem_wdata   <= is_st ? st_wdata : '0;
            dmem_wstrb   <= (is_st & ~mis) ? st_strb : 8'h00;
            out_pc       <= in_pc;
            out_rd_idx   <= in_rd_idx;
            out_rd_wen   <= ~is_mem & (in_rd_idx != '0);
            out_data     <= (mis | ~is_mem) ? in_alu_out : '0;
            out_misalign <= mis;
        end else if (state == WAIT && dmem_rsp_valid) begin
            out_data     <= ld_val;
            out_rd_wen   <= (out_rd_idx != '0);
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: byte-addressed reference memory model,
// an independent word-addressed bus responder, and a writeback monitor.
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`define MEMOP_NONE 4'd0
`define MEMOP_LB   4'd1
`define MEMOP_LBU  4'd2
`define MEMOP_LH   4'd3
`define MEMOP_LHU  4'd4
`define MEMOP_LW   4'd5
`define MEMOP_LWU  4'd6
`define MEMOP_LD   4'd7
`define MEMOP_SB   4'd8
`define MEMOP_SH   4'd9
`define MEMOP_SW   4'd10
`define MEMOP_SD   4'd11
`endif

module tb_mem_access;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] in_pc = '0, in_alu_out = '0, in_rs2_data = '0;
    logic [4:0]  in_rd_idx = '0;
    logic [3:0]  in_mem_op = '0;
    logic        dmem_req_valid, dmem_req_ready, dmem_wen, dmem_rsp_valid;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;
    logic        out_valid, out_ready = 1'b0, out_rd_wen, out_misalign;
    logic [63:0] out_pc, out_data;
    logic [4:0]  out_rd_idx;

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rd_idx(in_rd_idx), .in_alu_out(in_alu_out),
        .in_rs2_data(in_rs2_data), .in_mem_op(in_mem_op),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd_idx(out_rd_idx), .out_rd_wen(out_rd_wen), .out_data(out_data),
        .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [4:0] rd; logic wen; logic [63:0] data; logic mis; } out_t;
    typedef struct { logic [63:0] addr; logic wen; logic [63:0] wdata; logic [7:0] wstrb; } bus_t;

    out_t        oq[$];
    bus_t        bq[$];
    int          pop_cyc[$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          out_mode = 0, req_mode = 0, rsp_hold = 0, inject_cnt = 0;
    logic [7:0]  mmem[longint];
    logic [63:0] bmem[longint];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [7:0] init_byte(input longint a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mbyte(input longint a);
        if (mmem.exists(a)) return mmem[a];
        return init_byte(a);
    endfunction

    function automatic logic [63:0] bword(input longint a);
        logic [63:0] w;
        if (bmem.exists(a)) return bmem[a];
        for (int i = 0; i < 8; i++) w[8*i +: 8] = init_byte(a + longint'(i));
        return w;
    endfunction

    task automatic preset(input longint a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) mmem[a + longint'(i)] = v[8*i +: 8];
        bmem[a] = v;
    endtask

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            `MEMOP_LB, `MEMOP_LBU, `MEMOP_SB: return 1;
            `MEMOP_LH, `MEMOP_LHU, `MEMOP_SH: return 2;
            `MEMOP_LW, `MEMOP_LWU, `MEMOP_SW: return 4;
            `MEMOP_LD, `MEMOP_SD:             return 8;
            default:                          return 0;
        endcase
    endfunction

    // Architectural effect of one instruction: expected writeback, bus traffic, memory update.
    task automatic model(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] rs2,
                         input logic [4:0] rd, input logic [63:0] pc);
        int n = nbytes(op);
        logic st = (op >= `MEMOP_SB);
        logic sgn = (op == `MEMOP_LB) || (op == `MEMOP_LH) || (op == `MEMOP_LW);
        logic [63:0] v = '0, w = '0, al = {addr[63:3], 3'b000};
        if (n == 0) oq.push_back('{pc, rd, rd != 0, addr, 1'b0});
        else if (addr % 64'(n) != 0) oq.push_back('{pc, rd, 1'b0, addr, 1'b1});
        else if (st) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
            bq.push_back('{al, 1'b1, w, 8'(((1 << n) - 1) << (addr % 8))});
            for (int i = 0; i < n; i++) mmem[longint'(addr) + longint'(i)] = rs2[8*i +: 8];
            oq.push_back('{pc, rd, 1'b0, 64'd0, 1'b0});
        end else begin
            for (int i = 0; i < n; i++) v = v | (64'(mbyte(longint'(addr) + longint'(i))) << (8*i));
            if (sgn && v[8*n-1]) v = v | (~64'd0 << (8*n));
            bq.push_back('{al, 1'b0, 64'd0, 8'h00});
            oq.push_back('{pc, rd, rd != 0, v, 1'b0});
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] rs2,
                         input logic [4:0] rd, input logic [63:0] pc, output int acc);
        logic ok = 1'b0;
        acc = -1;
        in_mem_op = op; in_alu_out = addr; in_rs2_data = rs2; in_rd_idx = rd; in_pc = pc;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                acc = cyc;
                model(op, addr, rs2, rd, pc);
            end
        end
        if (!ok) bad("accept_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && oq.size() != 0; k++) @(posedge clk);
        if (oq.size() != 0) bad("drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ctl"}, {out_valid, out_rd_wen, out_misalign, dmem_req_valid, dmem_wen, in_ready}, 64'h01);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_out_pc_rd"}, {out_pc[58:0], out_rd_idx}, 64'd0);
        chk({tag, "_dmem_addr"}, dmem_addr, 64'd0);
        chk({tag, "_dmem_wdata_strb"}, dmem_wdata ^ {56'd0, dmem_wstrb}, 64'd0);
    endtask

    // Writeback monitor.
    initial begin
        out_t e, h;
        logic hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (hold) begin
                    chk("out_hold_data", out_data, h.data);
                    chk("out_hold_pc", out_pc, h.pc);
                    chk("out_hold_flags", {out_rd_idx, out_rd_wen, out_misalign}, {h.rd, h.wen, h.mis});
                end
                if (!out_ready) begin
                    chk("in_ready_stalled", in_ready, 64'd0);
                    h = '{out_pc, out_rd_idx, out_rd_wen, out_data, out_misalign};
                    hold = 1'b1;
                end else begin
                    hold = 1'b0;
                    if (oq.size() == 0) bad("unexpected_out_valid");
                    else begin
                        e = oq.pop_front();
                        pop_cyc.push_back(cyc);
                        chk("out_data", out_data, e.data);
                        chk("out_pc", out_pc, e.pc);
                        chk("out_rd_idx", out_rd_idx, e.rd);
                        chk("out_rd_wen", out_rd_wen, e.wen);
                        chk("out_misalign", out_misalign, e.mis);
                    end
                end
            end else hold = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        out_ready = (out_mode == 1) ? 1'b0 : (out_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    // Data-memory bus responder with its own word-addressed memory.
    initial begin
        bus_t e, h;
        logic hold = 1'b0, pend = 1'b0;
        int wt = 0, seen = 0;
        logic [63:0] rv = '0, w;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b0;
            if (inject_cnt != seen) begin
                seen = inject_cnt;
                dmem_rsp_valid = 1'b1;
                dmem_rdata = '1;
            end else if (pend && rsp_hold == 0) begin
                if (wt == 0) begin dmem_rsp_valid = 1'b1; dmem_rdata = rv; pend = 1'b0; end
                else wt--;
            end
            dmem_req_ready = (req_mode == 1) ? 1'b0 : (req_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (!rst_n) begin pend = 1'b0; hold = 1'b0; end
            else if (dmem_req_valid) begin
                if (hold) begin
                    chk("req_hold_addr", dmem_addr, h.addr);
                    chk("req_hold_wdata", dmem_wdata, h.wdata);
                    chk("req_hold_ctl", {dmem_wen, dmem_wstrb}, {h.wen, h.wstrb});
                end
                if (!dmem_req_ready) begin
                    h = '{dmem_addr, dmem_wen, dmem_wdata, dmem_wstrb};
                    hold = 1'b1;
                end else begin
                    hold = 1'b0;
                    if (bq.size() == 0) bad("unexpected_dmem_req");
                    else begin
                        e = bq.pop_front();
                        chk("dmem_addr", dmem_addr, e.addr);
                        chk("dmem_wen_wstrb", {dmem_wen, dmem_wstrb}, {e.wen, e.wstrb});
                        if (e.wen) begin
                            chk("dmem_wdata", dmem_wdata, e.wdata);
                            w = bword(longint'(dmem_addr));
                            for (int i = 0; i < 8; i++)
                                if (dmem_wstrb[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
                            bmem[longint'(dmem_addr)] = w;
                        end else begin
                            rv = bword(longint'(dmem_addr));
                            pend = 1'b1;
                            wt = $urandom_range(0, 2);
                        end
                    end
                end
            end else hold = 1'b0;
        end
    end

    initial begin
        int a1, a2;
        logic hs;
        logic [3:0] op;
        logic [63:0] addr;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pass-through, back-to-back.
        out_mode = 2;
        pop_cyc.delete();
        issue(`MEMOP_NONE, 64'h1234, 64'd0, 5'd5, 64'h100, a1);
        issue(`MEMOP_NONE, 64'h5678, 64'd0, 5'd0, 64'h104, a2);
        chk("b2b_accept_gap", 64'(a2 - a1), 64'd1);
        drain();
        if (pop_cyc.size() > 0) chk("pass_latency", 64'(pop_cyc[0] - a1), 64'd1);
        else bad("pass_no_output");

        // Load extension and store lanes.
        preset(64'h80000000, 64'h00000000_8F000000);
        issue(`MEMOP_LB,  64'h80000003, 64'd0, 5'd7, 64'h108, a1);
        issue(`MEMOP_LBU, 64'h80000003, 64'd0, 5'd8, 64'h10C, a1);
        issue(`MEMOP_SH,  64'h80000006, 64'hABCD, 5'd9, 64'h110, a1);
        issue(`MEMOP_LHU, 64'h80000006, 64'd0, 5'd10, 64'h114, a1);
        drain();

        // Bus and writeback backpressure.
        req_mode = 1;
        issue(`MEMOP_LW, 64'h80000004, 64'd0, 5'd11, 64'h118, a1);
        repeat (3) @(posedge clk);
        out_mode = 1;
        req_mode = 2;
        hs = 1'b0;
        for (int k = 0; k < 50 && !hs; k++) begin @(negedge clk); hs = out_valid; end
        if (!hs) bad("bp_out_valid_timeout");
        repeat (2) @(posedge clk);
        out_mode = 2;
        drain();

        // Misaligned load.
        issue(`MEMOP_LW, 64'h80000002, 64'd0, 5'd12, 64'h11C, a1);
        drain();

        // Reset while waiting for a load response.
        rsp_hold = 1;
        issue(`MEMOP_LD, 64'h80000010, 64'd0, 5'd13, 64'h120, a1);
        hs = 1'b0;
        for (int k = 0; k < 50 && !hs; k++) begin @(negedge clk); hs = dmem_req_valid & dmem_req_ready; end
        if (!hs) bad("wait_req_timeout");
        @(posedge clk); #1;
        rst_n = 1'b0;
        oq.delete();
        bq.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        rsp_hold = 0;
        inject_cnt++;
        @(negedge clk);
        check_idle("post_reset");
        @(negedge clk);
        check_idle("rsp_ignored");
        @(posedge clk); #1;

        // Random traffic.
        req_mode = 0;
        out_mode = 0;
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 11));
            addr = 64'h80000000 + 64'($urandom_range(0, 63));
            if (op == `MEMOP_NONE) addr = {$urandom, $urandom};
            issue(op, addr, {$urandom, $urandom}, 5'($urandom_range(0, 31)), {32'd0, $urandom}, a1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        if (bq.size() != 0) bad("bus_queue_not_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
